// File: rtl/mem_loader_pkg.sv
// Shared definitions for the memory loader: command opcodes, FSM state
// encodings and the per-memory address strides.
package mem_loader_pkg;

  localparam logic [1:0] OP_LOAD_IMEM = 2'd0;
  localparam logic [1:0] OP_LOAD_DMEM = 2'd1;
  localparam logic [1:0] OP_DUMP_DMEM = 2'd2;
  localparam logic [1:0] OP_RUN       = 2'd3;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_LOAD    = 3'd1;
  localparam state_t ST_RD_REQ  = 3'd2;
  localparam state_t ST_RD_WAIT = 3'd3;
  localparam state_t ST_RD_OUT  = 3'd4;
  localparam state_t ST_RUN     = 3'd5;
  localparam state_t ST_DONE    = 3'd6;

  // Instruction memory holds 32-bit words, data memory 64-bit words.
  localparam logic [63:0] IMEM_STRIDE = 64'd4;
  localparam logic [63:0] DMEM_STRIDE = 64'd8;

  function automatic logic [63:0] stride_for(input logic [1:0] op);
    return (op == OP_LOAD_IMEM) ? IMEM_STRIDE : DMEM_STRIDE;
  endfunction

endpackage

// File: rtl/mem_loader_counter.sv
// Loadable down-counter used for the word/cycle count and the read-latency
// wait. Reports when the count is zero and when it is on its last unit.
module loader_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         arst_n,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         dec,
  output logic         zero,
  output logic         one
);

  logic [W-1:0] count;

  // Load has priority over decrement; the count never wraps below zero.
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && !zero) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);
  assign one  = (count == W'(1));

endmodule

// File: rtl/mem_loader.sv
// Host-side initiator for the CPU's instruction and data memory ports.
// Streams words into either memory, dumps data memory, or runs the CPU for
// a bounded number of cycles; the CPU is only enabled while nothing else
// touches the memories.
module mem_loader
  import mem_loader_pkg::*;
#(
  parameter int RD_LAT = 1,
  parameter int LEN_W  = 16
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [63:0]      cmd_base,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [63:0]      wr_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [63:0]      rd_data,
  output logic             busy,
  output logic             done,
  output logic             cpu_enable,
  output logic [63:0]      addr_ext,
  output logic             wen_ext,
  output logic             ren_ext,
  output logic [31:0]      wdata_ext,
  output logic [63:0]      addr_ext_2,
  output logic             wen_ext_2,
  output logic             ren_ext_2,
  output logic [63:0]      wdata_ext_2,
  input  logic [63:0]      rdata_ext_2
);

  state_t      state;
  logic [1:0]  op;
  logic [63:0] addr;
  logic        wen_q;
  logic        wen2_q;
  logic [63:0] waddr_q;
  logic [63:0] wdata_q;

  logic cnt_load, cnt_dec, cnt_zero, cnt_one;
  logic lat_load, lat_dec, lat_zero, lat_one, lat_done;

  loader_counter #(.W(LEN_W)) u_word_cnt (
    .clk        (clk),
    .arst_n     (arst_n),
    .load       (cnt_load),
    .load_value (cmd_len),
    .dec        (cnt_dec),
    .zero       (cnt_zero),
    .one        (cnt_one)
  );

  loader_counter #(.W(3)) u_lat_cnt (
    .clk        (clk),
    .arst_n     (arst_n),
    .load       (lat_load),
    .load_value (3'(RD_LAT)),
    .dec        (lat_dec),
    .zero       (lat_zero),
    .one        (lat_one)
  );

  // Counter controls: one unit per write, per delivered read word or per run cycle.
  always_comb begin
    cnt_load = (state == ST_IDLE) && cmd_valid;
    cnt_dec  = ((state == ST_LOAD) && wr_valid) ||
               ((state == ST_RD_OUT) && rd_ready) ||
               (state == ST_RUN);
    lat_load = (state == ST_RD_REQ);
    lat_done = lat_one || lat_zero;
    lat_dec  = (state == ST_RD_WAIT) && !lat_done;
  end

  // Main sequencer; memory write strobes are registered and last one cycle.
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      state   <= ST_IDLE;
      op      <= OP_LOAD_IMEM;
      addr    <= '0;
      wen_q   <= 1'b0;
      wen2_q  <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      rd_data <= '0;
    end else begin
      wen_q   <= 1'b0;
      wen2_q  <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            op   <= cmd_op;
            addr <= cmd_base;
            if (cmd_len == '0) begin
              state <= ST_DONE;
            end else begin
              case (cmd_op)
                OP_DUMP_DMEM: state <= ST_RD_REQ;
                OP_RUN:       state <= ST_RUN;
                default:      state <= ST_LOAD;
              endcase
            end
          end
        end
        ST_LOAD: begin
          if (wr_valid) begin
            if (op == OP_LOAD_IMEM) begin
              wen_q   <= 1'b1;
              wdata_q <= {32'b0, wr_data[31:0]};
            end else begin
              wen2_q  <= 1'b1;
              wdata_q <= wr_data;
            end
            waddr_q <= addr;
            addr    <= addr + stride_for(op);
            if (cnt_one) begin
              state <= ST_DONE;
            end
          end
        end
        ST_RD_REQ: begin
          state <= ST_RD_WAIT;
        end
        ST_RD_WAIT: begin
          if (lat_done) begin
            rd_data <= rdata_ext_2;
            state   <= ST_RD_OUT;
          end
        end
        ST_RD_OUT: begin
          if (rd_ready) begin
            addr  <= addr + DMEM_STRIDE;
            state <= cnt_one ? ST_DONE : ST_RD_REQ;
          end
        end
        ST_RUN: begin
          if (cnt_one) begin
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Status, handshake and memory port outputs; idle ports are forced to zero.
  always_comb begin
    cmd_ready   = (state == ST_IDLE);
    busy        = (state != ST_IDLE);
    wr_ready    = (state == ST_LOAD);
    rd_valid    = (state == ST_RD_OUT);
    done        = (state == ST_DONE);
    cpu_enable  = (state == ST_RUN) && !cnt_zero;
    wen_ext     = wen_q;
    ren_ext     = 1'b0;
    addr_ext    = wen_q ? waddr_q : 64'b0;
    wdata_ext   = wen_q ? wdata_q[31:0] : 32'b0;
    wen_ext_2   = wen2_q;
    ren_ext_2   = (state == ST_RD_REQ);
    addr_ext_2  = wen2_q ? waddr_q : (ren_ext_2 ? addr : 64'b0);
    wdata_ext_2 = wen2_q ? wdata_q : 64'b0;
  end

endmodule

// File: tb/tb_mem_loader.sv
// Self-checking bench for mem_loader: a reference model builds expected
// memory traffic per command, and an independent monitor scores what the
// DUT actually drives on its ports.
module tb_mem_loader;
  import mem_loader_pkg::*;

  localparam int RD_LAT = 2;
  localparam int LEN_W  = 16;

  logic             clk;
  logic             arst_n;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [63:0]      cmd_base;
  logic [LEN_W-1:0] cmd_len;
  logic             wr_valid;
  logic             wr_ready;
  logic [63:0]      wr_data;
  logic             rd_valid;
  logic             rd_ready;
  logic [63:0]      rd_data;
  logic             busy;
  logic             done;
  logic             cpu_enable;
  logic [63:0]      addr_ext;
  logic             wen_ext;
  logic             ren_ext;
  logic [31:0]      wdata_ext;
  logic [63:0]      addr_ext_2;
  logic             wen_ext_2;
  logic             ren_ext_2;
  logic [63:0]      wdata_ext_2;
  logic [63:0]      rdata_ext_2;

  mem_loader #(.RD_LAT(RD_LAT), .LEN_W(LEN_W)) dut (
    .clk         (clk),
    .arst_n      (arst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_base    (cmd_base),
    .cmd_len     (cmd_len),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_data     (wr_data),
    .rd_valid    (rd_valid),
    .rd_ready    (rd_ready),
    .rd_data     (rd_data),
    .busy        (busy),
    .done        (done),
    .cpu_enable  (cpu_enable),
    .addr_ext    (addr_ext),
    .wen_ext     (wen_ext),
    .ren_ext     (ren_ext),
    .wdata_ext   (wdata_ext),
    .addr_ext_2  (addr_ext_2),
    .wen_ext_2   (wen_ext_2),
    .ren_ext_2   (ren_ext_2),
    .wdata_ext_2 (wdata_ext_2),
    .rdata_ext_2 (rdata_ext_2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] addr;
    logic [63:0] data;
  } xact_t;

  int checks = 0;
  int passes = 0;

  // Scoreboard queues filled when a command is issued.
  xact_t       exp_imem[$];
  xact_t       exp_dmem[$];
  logic [63:0] exp_rd_addr[$];
  logic [63:0] exp_rd_data[$];
  int          exp_en   = 0;
  int          exp_done = 0;

  // Reference view of data memory, and the memory the DUT actually writes.
  bit [63:0] ref_mem[bit [63:0]];
  bit [63:0] sram[bit [63:0]];
  logic [63:0] pipe[1:RD_LAT];

  logic [63:0] wr_q[$];
  logic [63:0] pend[$];
  int wr_mode, rd_mode, stall_left;
  bit mon_on;
  bit wr_toggle;

  function automatic bit [63:0] dflt(input bit [63:0] a);
    return a ^ 64'hC0DE_0000_5EED_1234;
  endfunction

  function automatic bit [63:0] ref_rd(input bit [63:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  function automatic bit [63:0] sram_rd(input bit [63:0] a);
    return sram.exists(a) ? sram[a] : dflt(a);
  endfunction

  task automatic check_output(input bit ok, input string name,
                              input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (ok) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
  endtask

  // Data memory model with RD_LAT cycles of read latency.
  always @(posedge clk) begin
    if (wen_ext_2) sram[addr_ext_2] = wdata_ext_2;
    pipe[1] <= ren_ext_2 ? sram_rd(addr_ext_2) : 64'hBAD0_BAD0_BAD0_BAD0;
    for (int i = 2; i <= RD_LAT; i++) pipe[i] <= pipe[i-1];
    rdata_ext_2 <= ren_ext_2 && (RD_LAT == 1) ? sram_rd(addr_ext_2) : pipe[RD_LAT-1 > 0 ? RD_LAT-1 : 1];
  end

  // Write-stream feeder: 0 = continuous, 1 = every other cycle, 2 = random gaps.
  always begin
    bit hs;
    @(negedge clk);
    hs = wr_valid && wr_ready;
    @(posedge clk);
    #1;
    if (hs && wr_q.size() > 0) void'(wr_q.pop_front());
    wr_toggle = ~wr_toggle;
    if (wr_q.size() > 0) begin
      case (wr_mode)
        0:       wr_valid = 1'b1;
        1:       wr_valid = wr_toggle;
        default: wr_valid = ($urandom_range(0, 99) >= 40);
      endcase
      wr_data = wr_q[0];
    end else begin
      wr_valid = 1'b0;
      wr_data  = '0;
    end
  end

  // Dump-stream consumer: 0 = always ready, 1 = random stalls, 2 = directed stall.
  always begin
    @(posedge clk);
    #1;
    case (rd_mode)
      0: rd_ready = 1'b1;
      1: rd_ready = ($urandom_range(0, 2) != 0);
      default: begin
        if (rd_valid && stall_left > 0) begin
          rd_ready = 1'b0;
          stall_left--;
        end else begin
          rd_ready = 1'b1;
        end
      end
    endcase
  end

  // Monitor: score every strobe, read word and completion against the queues.
  xact_t       mx;
  logic [63:0] mv;
  bit          prev_stall;
  logic [63:0] prev_rd;
  always @(negedge clk) begin
    if (mon_on) begin
      check_output($onehot0({wen_ext, wen_ext_2, ren_ext_2, cpu_enable}) && !ren_ext,
                   "strobe_exclusive", {59'b0, ren_ext, wen_ext, wen_ext_2, ren_ext_2, cpu_enable}, 64'h0);
      check_output((wen_ext || (addr_ext == 0 && wdata_ext == 0)) &&
                   (wen_ext_2 || wdata_ext_2 == 0) &&
                   (wen_ext_2 || ren_ext_2 || addr_ext_2 == 0),
                   "ports_quiet", addr_ext | addr_ext_2, 64'h0);
      if (wen_ext) begin
        if (exp_imem.size() == 0) check_output(0, "imem_unexpected", addr_ext, 64'h0);
        else begin
          mx = exp_imem.pop_front();
          check_output(addr_ext == mx.addr, "imem_addr", addr_ext, mx.addr);
          check_output(wdata_ext == mx.data[31:0], "imem_data", {32'b0, wdata_ext}, mx.data);
        end
      end
      if (wen_ext_2) begin
        if (exp_dmem.size() == 0) check_output(0, "dmem_unexpected", addr_ext_2, 64'h0);
        else begin
          mx = exp_dmem.pop_front();
          check_output(addr_ext_2 == mx.addr, "dmem_addr", addr_ext_2, mx.addr);
          check_output(wdata_ext_2 == mx.data, "dmem_data", wdata_ext_2, mx.data);
        end
      end
      if (ren_ext_2) begin
        if (exp_rd_addr.size() == 0) check_output(0, "ren_unexpected", addr_ext_2, 64'h0);
        else begin
          mv = exp_rd_addr.pop_front();
          check_output(addr_ext_2 == mv, "ren_addr", addr_ext_2, mv);
        end
      end
      if (cpu_enable) begin
        check_output(exp_en > 0, "enable_extra", 64'(exp_en), 64'h1);
        if (exp_en > 0) exp_en--;
      end
      if (prev_stall) check_output(rd_valid && rd_data == prev_rd, "rd_hold", rd_data, prev_rd);
      if (rd_valid && rd_ready) begin
        if (exp_rd_data.size() == 0) check_output(0, "rd_unexpected", rd_data, 64'h0);
        else begin
          mv = exp_rd_data.pop_front();
          check_output(rd_data == mv, "rd_data", rd_data, mv);
        end
      end
      prev_stall = rd_valid && !rd_ready;
      prev_rd    = rd_data;
      if (done) begin
        check_output(exp_done > 0, "done_unexpected", 64'(exp_done), 64'h1);
        if (exp_done > 0) exp_done--;
        check_output(exp_imem.size() == 0 && exp_dmem.size() == 0 && exp_rd_addr.size() == 0 &&
                     exp_rd_data.size() == 0 && exp_en == 0, "cmd_drained",
                     64'(exp_imem.size() + exp_dmem.size() + exp_rd_addr.size() + exp_rd_data.size() + exp_en), 64'h0);
      end
    end else begin
      prev_stall = 1'b0;
    end
  end

  // Issue one command: build the reference traffic, handshake, await done.
  task automatic apply_stimulus(input logic [1:0] op, input logic [63:0] base, input int len,
                                input bit chk_lat, input bit hold_extra);
    logic [63:0] w, a;
    int cyc;
    bit acc, got;
    for (int i = 0; i < len; i++) begin
      case (op)
        OP_LOAD_IMEM, OP_LOAD_DMEM: begin
          w = (pend.size() > 0) ? pend.pop_front() : {$urandom, $urandom};
          a = base + 64'(i) * ((op == OP_LOAD_IMEM) ? 64'd4 : 64'd8);
          if (op == OP_LOAD_IMEM) exp_imem.push_back({a, 32'b0, w[31:0]});
          else begin
            exp_dmem.push_back({a, w});
            ref_mem[a] = w;
          end
          wr_q.push_back(w);
        end
        OP_DUMP_DMEM: begin
          a = base + 64'(i) * 64'd8;
          exp_rd_addr.push_back(a);
          exp_rd_data.push_back(ref_rd(a));
        end
        default: exp_en++;
      endcase
    end
    exp_done++;
    @(posedge clk);
    #1;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_base  = base;
    cmd_len   = LEN_W'(len);
    acc = 1'b0;
    for (int t = 0; t < 50 && !acc; t++) begin
      @(negedge clk);
      acc = cmd_ready;
    end
    check_output(acc, "cmd_accept", {63'b0, acc}, 64'h1);
    @(posedge clk);
    #1;
    if (hold_extra) begin
      cmd_op   = OP_LOAD_IMEM;
      cmd_base = 64'h40;
      cmd_len  = LEN_W'(1);
    end else begin
      cmd_valid = 1'b0;
    end
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 400) begin
      @(negedge clk);
      cyc++;
      check_output(busy && !cmd_ready, "busy_during_cmd", {62'b0, cmd_ready, busy}, 64'h1);
      if (done) begin
        got = 1'b1;
        cmd_valid = 1'b0;
      end
    end
    cmd_valid = 1'b0;
    check_output(got, "done_timeout", 64'(cyc), 64'h0);
    if (chk_lat) check_output(cyc == len + 1, "done_latency", 64'(cyc), 64'(len + 1));
    @(negedge clk);
    check_output(!busy && cmd_ready && !done, "idle_after_done", {61'b0, done, cmd_ready, busy}, 64'h2);
  endtask

  initial begin
    logic [1:0]  rop;
    logic [63:0] rbase;
    arst_n = 1'b0;
    cmd_valid = 1'b0; cmd_op = '0; cmd_base = '0; cmd_len = '0;
    wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b1;
    wr_mode = 0; rd_mode = 0; stall_left = 0; mon_on = 1'b0; wr_toggle = 1'b0;
    prev_stall = 1'b0; prev_rd = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_output(cmd_ready && !busy && !done && !wr_ready && !rd_valid && !cpu_enable &&
                 !wen_ext && !wen_ext_2 && !ren_ext && !ren_ext_2 && rd_data == 0 &&
                 addr_ext == 0 && addr_ext_2 == 0 && wdata_ext == 0 && wdata_ext_2 == 0,
                 "reset_state", {63'b0, cmd_ready}, 64'h1);
    arst_n = 1'b1;
    mon_on = 1'b1;

    pend = '{64'h0050_0093, 64'h00A0_0113, 64'h0020_81B3};
    apply_stimulus(OP_LOAD_IMEM, 64'h0, 3, 1'b0, 1'b0);

    wr_mode = 1;
    apply_stimulus(OP_LOAD_DMEM, 64'h10, 2, 1'b0, 1'b0);
    wr_mode = 0;

    rd_mode = 2;
    stall_left = 3;
    apply_stimulus(OP_DUMP_DMEM, 64'h10, 2, 1'b0, 1'b0);
    rd_mode = 0;

    apply_stimulus(OP_RUN, 64'h0, 5, 1'b1, 1'b1);

    for (int o = 0; o < 4; o++) apply_stimulus(2'(o), 64'h80, 0, 1'b1, 1'b0);

    apply_stimulus(OP_LOAD_DMEM, 64'hFFFF_FFFF_FFFF_FFF8, 2, 1'b0, 1'b0);
    apply_stimulus(OP_DUMP_DMEM, 64'hFFFF_FFFF_FFFF_FFF8, 2, 1'b0, 1'b0);

    // Reset lands on the edge that would accept word 1 of a 4-word load.
    pend = '{64'h1111, 64'h2222, 64'h3333, 64'h4444};
    for (int i = 0; i < 4; i++) wr_q.push_back(pend[i]);
    exp_dmem.push_back({64'h200, 64'h1111});
    ref_mem[64'h200] = 64'h1111;
    pend.delete();
    @(posedge clk);
    #1;
    cmd_valid = 1'b1; cmd_op = OP_LOAD_DMEM; cmd_base = 64'h200; cmd_len = LEN_W'(4);
    @(negedge clk);
    check_output(cmd_ready, "rst_cmd_accept", {63'b0, cmd_ready}, 64'h1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    arst_n = 1'b0;
    wr_q.delete();
    @(negedge clk);
    check_output(cmd_ready && !busy && !done && !wr_ready && !rd_valid && !cpu_enable &&
                 !wen_ext && !wen_ext_2 && !ren_ext_2 && rd_data == 0 &&
                 addr_ext == 0 && addr_ext_2 == 0 && wdata_ext_2 == 0,
                 "reset_midop", {63'b0, wen_ext_2}, 64'h0);
    arst_n = 1'b1;
    apply_stimulus(OP_DUMP_DMEM, 64'h200, 2, 1'b0, 1'b0);

    for (int n = 0; n < 25; n++) begin
      rop = 2'($urandom_range(0, 3));
      wr_mode = $urandom_range(0, 2);
      rd_mode = $urandom_range(0, 1);
      case (rop)
        OP_LOAD_IMEM: rbase = {$urandom, $urandom} & ~64'h3;
        OP_RUN:       rbase = {$urandom, $urandom};
        default:      rbase = ($urandom_range(0, 4) == 0) ? 64'hFFFF_FFFF_FFFF_FFE0 :
                               64'h1000 + 64'(8 * $urandom_range(0, 15));
      endcase
      apply_stimulus(rop, rbase, $urandom_range(0, 6), rop == OP_RUN, 1'b0);
    end

    repeat (4) @(negedge clk);
    check_output(exp_done == 0 && exp_imem.size() == 0 && exp_dmem.size() == 0 &&
                 exp_rd_data.size() == 0 && exp_en == 0, "final_drain", 64'(exp_done), 64'h0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
